// File: rtl/uart_regbank_ctrl_if.sv
// uart_regbank_ctrl_if: byte-level rx/tx handshake between the RS232 cores and the register-bank controller.
interface uart_regbank_ctrl_if;
   logic [7:0] rxdw;
   logic rxrdy;
   logic txbusy;
   logic [7:0] txdw;
   logic txena;
   modport master(output rxdw, rxrdy, txbusy, input txdw, txena);
   modport slave(input rxdw, rxrdy, txbusy, output txdw, txena);
endinterface

// File: rtl/uart_regbank_ctrl.sv
// uart_regbank_ctrl: decodes W/R byte frames from rx into a config register bank and serialises ACK/NAK/read data to tx.
module uart_regbank_ctrl #(
   parameter int NREGS = 4,
   parameter int DW = 16,
   parameter logic [7:0] WR_CMD = 8'h57,
   parameter logic [7:0] RD_CMD = 8'h52,
   parameter int TIMEOUT = 1000000
) (
   input  logic clk,
   input  logic rst,
   uart_regbank_ctrl_if.slave u,
   output logic [NREGS*DW-1:0] regs,
   output logic reg_wr,
   output logic [7:0] reg_addr,
   output logic busy,
   output logic err,
   output logic [2:0] sleds
);
   localparam int NB = DW / 8;
   localparam int TW = $clog2(TIMEOUT + 1);
   localparam logic [2:0] IDLE = 3'd0, GET_ADDR = 3'd1, GET_DATA = 3'd2, COMMIT = 3'd3,
                          RD_LOAD = 3'd4, TX_SEND = 3'd5, TX_WAIT = 3'd6, TX_DRAIN = 3'd7;
   logic [2:0] state;
   logic op;
   logic [7:0] addr, cnt;
   logic [TW-1:0] tmr;
   logic [DW-1:0] sr, txsr, rd_val;
   assign busy = state != IDLE;
   assign sleds = state;
   always_comb begin
      rd_val = '0;
      for (int k = 0; k < NREGS; k++) rd_val = (addr == 8'(k)) ? regs[k*DW +: DW] : rd_val;
   end
   // cnt counts received data bytes while writing, and bytes still to send while replying to a read
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= IDLE;
         op <= 1'b0;
         addr <= '0;
         cnt <= '0;
         tmr <= '0;
         sr <= '0;
         txsr <= '0;
         regs <= '0;
         u.txdw <= '0;
         u.txena <= 1'b0;
         reg_wr <= 1'b0;
         reg_addr <= '0;
         err <= 1'b0;
      end else begin
         u.txena <= 1'b0;
         reg_wr <= 1'b0;
         err <= 1'b0;
         case (state)
            IDLE: if (u.rxrdy && (u.rxdw == WR_CMD || u.rxdw == RD_CMD)) begin
               op <= u.rxdw == WR_CMD;
               cnt <= '0;
               tmr <= '0;
               state <= GET_ADDR;
            end
            GET_ADDR: if (u.rxrdy) begin
               addr <= u.rxdw;
               tmr <= '0;
               if (int'(u.rxdw) >= NREGS) begin
                  err <= 1'b1;
                  u.txdw <= 8'h15;
                  state <= TX_SEND;
               end else state <= op ? GET_DATA : RD_LOAD;
            end else if (tmr == TW'(TIMEOUT - 1)) begin
               err <= 1'b1;
               state <= IDLE;
            end else tmr <= tmr + TW'(1);
            GET_DATA: if (u.rxrdy) begin
               sr <= DW'({sr, u.rxdw});
               tmr <= '0;
               cnt <= (cnt == 8'(NB - 1)) ? 8'd0 : cnt + 8'd1;
               state <= (cnt == 8'(NB - 1)) ? COMMIT : GET_DATA;
            end else if (tmr == TW'(TIMEOUT - 1)) begin
               err <= 1'b1;
               state <= IDLE;
            end else tmr <= tmr + TW'(1);
            COMMIT: begin
               for (int k = 0; k < NREGS; k++) if (addr == 8'(k)) regs[k*DW +: DW] <= sr;
               reg_wr <= 1'b1;
               reg_addr <= addr;
               u.txdw <= 8'h06;
               state <= TX_SEND;
            end
            RD_LOAD: begin
               txsr <= rd_val;
               cnt <= 8'(NB);
               state <= TX_SEND;
            end
            TX_SEND: if (!u.txbusy) begin
               u.txena <= 1'b1;
               if (cnt != 8'd0) begin
                  u.txdw <= txsr[DW-1 -: 8];
                  txsr <= txsr << 8;
                  cnt <= cnt - 8'd1;
               end
               state <= TX_WAIT;
            end
            TX_WAIT: state <= TX_DRAIN;
            default: if (!u.txbusy) state <= (cnt != 8'd0) ? TX_SEND : IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_uart_regbank_ctrl.sv
// tb_uart_regbank_ctrl: directed frame tests against hand-computed register, reply and pulse expectations.
module tb_uart_regbank_ctrl;
   logic clk = 1'b0;
   logic rst = 1'b0;
   logic ext_busy = 1'b0;
   logic [3:0] bcnt = '0;
   logic [63:0] regs;
   logic reg_wr, busy, err;
   logic [7:0] reg_addr;
   logic [2:0] sleds;
   int checks = 0, errors = 0;
   int n_txena = 0, n_err = 0, n_regwr = 0, n_both = 0, n_viol = 0;
   logic [7:0] txq[$];
   uart_regbank_ctrl_if u();
   uart_regbank_ctrl #(.NREGS(4), .DW(16), .TIMEOUT(64)) dut (
      .clk(clk), .rst(rst), .u(u.slave), .regs(regs), .reg_wr(reg_wr),
      .reg_addr(reg_addr), .busy(busy), .err(err), .sleds(sleds));
   always #5 clk = ~clk;
   always @(posedge clk) bcnt <= u.txena ? 4'd6 : (bcnt != 0 ? bcnt - 4'd1 : 4'd0);
   assign u.txbusy = ext_busy || bcnt != 0;
   always @(negedge clk) begin
      if (u.txena) begin
         n_txena++;
         txq.push_back(u.txdw);
         if (u.txbusy) n_viol++;
      end
      if (err) n_err++;
      if (reg_wr) n_regwr++;
      if (err && reg_wr) n_both++;
   end
   task automatic clr();
      n_txena = 0; n_err = 0; n_regwr = 0; txq.delete();
   endtask
   task automatic send(input logic [7:0] b);
      u.rxdw = b; u.rxrdy = 1'b1;
      @(posedge clk); #1;
      u.rxrdy = 1'b0;
   endtask
   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask
   task automatic wait_idle();
      int n = 0;
      while (busy && n < 500) begin @(posedge clk); #1; n++; end
      checks++;
      if (busy) begin errors++; $display("FAIL wait_idle: busy=%b after %0d cycles, required 0", busy, n); end
   endtask
   task automatic test_reset();
      #12;
      checks++;
      if (regs !== 64'h0 || reg_addr !== 8'h0) begin errors++; $display("FAIL reset_regs: regs=%h reg_addr=%h, required 0", regs, reg_addr); end
      checks++;
      if ({u.txena, reg_wr, busy, err} !== 4'b0 || u.txdw !== 8'h0 || sleds !== 3'd0) begin
         errors++; $display("FAIL reset_outs: txena=%b reg_wr=%b busy=%b err=%b txdw=%h sleds=%0d, required all 0", u.txena, reg_wr, busy, err, u.txdw, sleds);
      end
      @(negedge clk); rst = 1'b1;
      idle(2);
   endtask
   task automatic test_write();
      clr();
      send(8'h57); send(8'h02); send(8'hAB); send(8'hCD);
      checks++;
      if (reg_wr !== 1'b0 || regs[47:32] !== 16'h0) begin errors++; $display("FAIL write_early: reg_wr=%b reg2=%h, required 0/0000", reg_wr, regs[47:32]); end
      @(posedge clk); #1;
      checks++;
      if (reg_wr !== 1'b1 || regs !== 64'h0000_ABCD_0000_0000 || reg_addr !== 8'h02) begin
         errors++; $display("FAIL write_commit: reg_wr=%b regs=%h reg_addr=%h, required 1/0000abcd00000000/02", reg_wr, regs, reg_addr);
      end
      wait_idle();
      checks++;
      if (n_txena !== 1 || txq.size() != 1 || txq[0] !== 8'h06 || n_err !== 0) begin
         errors++; $display("FAIL write_ack: txena=%0d first=%h err=%0d, required 1/06/0", n_txena, txq.size() ? txq[0] : 8'hxx, n_err);
      end
   endtask
   task automatic test_read();
      clr();
      ext_busy = 1'b1;
      send(8'h52); send(8'h02);
      idle(20);
      checks++;
      if (n_txena !== 0 || sleds !== 3'd5) begin errors++; $display("FAIL read_stall: txena=%0d sleds=%0d, required 0/5", n_txena, sleds); end
      ext_busy = 1'b0;
      wait_idle();
      checks++;
      if (n_txena !== 2 || txq.size() != 2 || txq[0] !== 8'hAB || txq[1] !== 8'hCD) begin
         errors++; $display("FAIL read_data: txena=%0d bytes=%0d first=%h, required 2/2/ab then cd", n_txena, txq.size(), txq.size() ? txq[0] : 8'hxx);
      end
      checks++;
      if (busy !== 1'b0 || n_viol !== 0) begin errors++; $display("FAIL read_end: busy=%b txena_while_busy=%0d, required 0/0", busy, n_viol); end
   endtask
   task automatic test_bad_addr();
      clr();
      send(8'h57); send(8'h05);
      checks++;
      if (err !== 1'b1) begin errors++; $display("FAIL bad_err: err=%b, required 1", err); end
      wait_idle();
      send(8'hAB); send(8'hCD);
      idle(10);
      checks++;
      if (n_txena !== 1 || txq.size() != 1 || txq[0] !== 8'h15 || n_err !== 1) begin
         errors++; $display("FAIL bad_nak: txena=%0d first=%h err=%0d, required 1/15/1", n_txena, txq.size() ? txq[0] : 8'hxx, n_err);
      end
      checks++;
      if (regs !== 64'h0000_ABCD_0000_0000 || busy !== 1'b0) begin errors++; $display("FAIL bad_regs: regs=%h busy=%b, required 0000abcd00000000/0", regs, busy); end
   endtask
   task automatic test_timeout();
      int n = 0;
      clr();
      send(8'h57); send(8'h01); send(8'h12);
      while (!err && n < 80) begin @(posedge clk); #1; n++; end
      checks++;
      if (n !== 64 || err !== 1'b1) begin errors++; $display("FAIL timeout_cycle: err after %0d cycles, required 64", n); end
      idle(1);
      checks++;
      if (sleds !== 3'd0 || regs !== 64'h0000_ABCD_0000_0000 || n_txena !== 0) begin
         errors++; $display("FAIL timeout_abort: sleds=%0d regs=%h txena=%0d, required 0/0000abcd00000000/0", sleds, regs, n_txena);
      end
      send(8'h57); send(8'h01); send(8'h12); send(8'h34);
      wait_idle();
      checks++;
      if (regs !== 64'h0000_ABCD_1234_0000 || n_txena !== 1 || txq[0] !== 8'h06) begin
         errors++; $display("FAIL timeout_retry: regs=%h txena=%0d, required 0000abcd12340000/1", regs, n_txena);
      end
   endtask
   task automatic test_reset_mid();
      int n = 0;
      send(8'h57); send(8'h03); send(8'h55);
      checks++;
      if (sleds !== 3'd2) begin errors++; $display("FAIL mid_state: sleds=%0d, required 2", sleds); end
      rst = 1'b0; #1;
      checks++;
      if (regs !== 64'h0 || busy !== 1'b0 || sleds !== 3'd0 || reg_addr !== 8'h0) begin
         errors++; $display("FAIL mid_rst_data: regs=%h busy=%b sleds=%0d reg_addr=%h, required 0", regs, busy, sleds, reg_addr);
      end
      @(negedge clk); rst = 1'b1;
      clr();
      idle(10);
      checks++;
      if (n_regwr !== 0 || n_txena !== 0) begin errors++; $display("FAIL mid_after_data: reg_wr=%0d txena=%0d, required 0/0", n_regwr, n_txena); end
      send(8'h57); send(8'h00); send(8'h11); send(8'h22);
      while (sleds !== 3'd7 && n < 100) begin @(posedge clk); #1; n++; end
      rst = 1'b0; #1;
      checks++;
      if (sleds !== 3'd0 || u.txena !== 1'b0 || u.txdw !== 8'h0 || regs !== 64'h0 || err !== 1'b0) begin
         errors++; $display("FAIL mid_rst_drain: sleds=%0d txena=%b txdw=%h regs=%h err=%b, required 0", sleds, u.txena, u.txdw, regs, err);
      end
      @(negedge clk); rst = 1'b1;
      clr();
      idle(20);
      checks++;
      if (n_regwr !== 0 || n_txena !== 0 || busy !== 1'b0) begin errors++; $display("FAIL mid_after_drain: reg_wr=%0d txena=%0d busy=%b, required 0", n_regwr, n_txena, busy); end
   endtask
   task automatic test_noise();
      clr();
      send(8'h00); send(8'hFF); send(8'h41);
      checks++;
      if (busy !== 1'b0) begin errors++; $display("FAIL noise_busy: busy=%b, required 0", busy); end
      idle(10);
      checks++;
      if (n_txena !== 0 || n_err !== 0) begin errors++; $display("FAIL noise_quiet: txena=%0d err=%0d, required 0/0", n_txena, n_err); end
   endtask
   task automatic test_back_to_back();
      clr();
      send(8'h57); send(8'h03); send(8'h00); send(8'h07);
      wait_idle();
      send(8'h52); send(8'h03);
      wait_idle();
      checks++;
      if (txq.size() != 3 || txq[0] !== 8'h06 || txq[1] !== 8'h00 || txq[2] !== 8'h07) begin
         errors++; $display("FAIL b2b_reply: bytes=%0d, required 3 bytes 06 00 07", txq.size());
      end
      checks++;
      if (regs !== 64'h0007_0000_0000_0000 || n_both !== 0) begin errors++; $display("FAIL b2b_regs: regs=%h err_and_wr=%0d, required 0007000000000000/0", regs, n_both); end
   endtask
   initial begin
      u.rxdw = 8'h0; u.rxrdy = 1'b0;
      test_reset();
      test_write();
      test_read();
      test_bad_addr();
      test_timeout();
      test_reset_mid();
      test_noise();
      test_back_to_back();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
